// File: rtl/bus_send_arbiter.sv
// Round-robin arbiter sharing one bus-adapter send port among NUM_REQ sources.
// The winner is captured into a one-entry output register. A drain and a refill can happen in the same cycle.
module bus_send_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = 8,
  parameter  int TAG_W   = 8,
  parameter  int DATA_W  = 64,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [TAG_W-1:0]            out_tag,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src
);

  logic [SRC_W-1:0]  r_ptr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;
  logic [SRC_W-1:0]  r_src;

  logic              w_can_accept;
  logic              w_found;
  logic [SRC_W-1:0]  w_win;
  logic              w_xfer;
  logic [SRC_W-1:0]  w_ptr_nxt;

  assign w_can_accept = !r_valid || out_ready;

  // Search upward from r_ptr with wrap; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = SRC_W'(idx);
      end
    end
  end

  assign w_xfer    = w_found && w_can_accept;
  assign w_ptr_nxt = (w_win == SRC_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
    assign req_ready[g] = w_xfer && (w_win == SRC_W'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_tag   <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
      r_tag   <= req_tag[w_win*TAG_W +: TAG_W];
      r_data  <= req_data[w_win*DATA_W +: DATA_W];
      r_src   <= w_win;
      r_ptr   <= w_ptr_nxt;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_addr  = r_addr;
  assign out_tag   = r_tag;
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: tb/tb_bus_send_arbiter.sv
// Directed bench for bus_send_arbiter covering rotation, stall, single source, wrap, drain and async reset.
module tb_bus_send_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int TAG_W   = 8;
  localparam int DATA_W  = 64;
  localparam int SRC_W   = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [ADDR_W-1:0]         out_addr;
  logic [TAG_W-1:0]          out_tag;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;

  int errs   = 0;
  int checks = 0;

  bus_send_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_tag(req_tag), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_tag(out_tag), .out_data(out_data), .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_slot(input int i, input logic [7:0] a, input logic [7:0] t, input logic [63:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
    req_addr = '0; req_tag = '0; req_data = '0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  out_data, 64'd0);
    chk("rst_src",   64'(out_src), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    #11 rst_n = 1'b1;

    // All four requesting: strict rotation 0,1,2,3,0,1,2,3 with no gaps.
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 8'(8'h10 + i), 8'(i), 64'(64'h100 + i));
    tick();
    req_valid = 4'b1111; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      chk("rr_ready", 64'(req_ready), 64'(exp_rdy));
      tick();
      chk("rr_src",   64'(out_src), 64'(k % 4));
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_data",  out_data, 64'(64'h100 + (k % 4)));
    end
    req_valid = '0;
    tick();
    chk("rr_drain", 64'(out_valid), 64'd0);

    // Hold src 2 under backpressure; next grant must go to index 3.
    set_slot(2, 8'h12, 8'h05, 64'hDEAD);
    req_valid = 4'b0100; out_ready = 1'b0;
    tick();
    chk("st_src", 64'(out_src), 64'd2);
    req_valid = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("st_ready", 64'(req_ready), 64'd0);
      chk("st_valid", 64'(out_valid), 64'd1);
      chk("st_addr",  64'(out_addr), 64'h12);
      chk("st_tag",   64'(out_tag), 64'h05);
      chk("st_data",  out_data, 64'hDEAD);
      chk("st_src2",  64'(out_src), 64'd2);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("st_rel_ready", 64'(req_ready), 64'b1000);
    tick();
    chk("st_rel_src", 64'(out_src), 64'd3);
    req_valid = '0;
    tick();
    chk("st_drain", 64'(out_valid), 64'd0);

    // Single active requester gets back-to-back slots (ptr now 0).
    req_valid = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      set_slot(1, 8'h21, 8'h01, 64'(k));
      #1;
      chk("one_ready", 64'(req_ready), 64'b0010);
      tick();
      chk("one_data",  out_data, 64'(k));
      chk("one_src",   64'(out_src), 64'd1);
      chk("one_valid", 64'(out_valid), 64'd1);
    end
    // ptr = 2; one grant to 2 moves it to 3.
    req_valid = 4'b0100;
    tick();
    chk("wr_pre", 64'(out_src), 64'd2);
    req_valid = 4'b1001;
    tick(); chk("wr_g0", 64'(out_src), 64'd3);
    tick(); chk("wr_g1", 64'(out_src), 64'd0);
    tick(); chk("wr_g2", 64'(out_src), 64'd3);

    // Drain with nothing requesting; ptr stays 0.
    req_valid = '0;
    tick();
    chk("dr_valid", 64'(out_valid), 64'd0);
    tick();
    chk("dr_idle", 64'(out_valid), 64'd0);
    req_valid = 4'b1111;
    #1;
    chk("dr_ptr", 64'(req_ready), 64'b0001);
    req_valid = 4'b0100;
    #1;
    chk("dr_ready2", 64'(req_ready), 64'b0100);
    tick();
    chk("dr_src",   64'(out_src), 64'd2);
    chk("dr_valid2", 64'(out_valid), 64'd1);

    // ptr = 3; grants 3,0,1 leave ptr = 2 with src 1 held.
    req_valid = 4'b1011;
    tick(); tick(); tick();
    chk("ar_pre", 64'(out_src), 64'd1);
    req_valid = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_data",  out_data, 64'd0);
    chk("ar_addr",  64'(out_addr), 64'd0);
    chk("ar_src",   64'(out_src), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_novalid", 64'(out_valid), 64'd0);
    req_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("ar_ready", 64'(req_ready), 64'b0001);
    tick();
    chk("ar_src0", 64'(out_src), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bus_send_arbiter.md
Name: bus_send_arbiter

Overview:
- Shares the single send port of the network bus adapter among NUM_REQ independent message sources (e.g. per-core postoffice send queues).
- Round-robin arbitration picks one source per cycle. The winner's message is captured into a one-entry output register, which drives the adapter's send valid/ready/data port.
- Provides fairness and full-throughput back-to-back transfers.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- ADDR_W, 8, destination address width
- TAG_W, 8, message tag width
- DATA_W, 64, message payload width
- SRC_W, $clog2(NUM_REQ), width of granted source index (derived, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester message valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; slot i at [i*ADDR_W +: ADDR_W]
- req_tag  in  NUM_REQ*TAG_W  packed tags; same packing
- req_data  in  NUM_REQ*DATA_W  packed payloads; same packing
- out_valid  out  1  message held for bus adapter
- out_ready  in  1  bus adapter accepts held message
- out_addr  out  ADDR_W  held destination
- out_tag  out  TAG_W  held tag
- out_data  out  DATA_W  held payload
- out_src  out  SRC_W  index of requester that supplied the held message

Behaviour:
- Reset values (asynchronous on rst_n low):
  - out_valid=0; out_addr, out_tag, out_data and out_src all 0.
  - rr_ptr=0.
  - req_ready is combinational, so it follows the reset state of the registers.
- can_accept = !out_valid | out_ready (combinational). A held message and a new one may exchange in the same cycle.
- Winner selection:
  - Search req_valid starting at index rr_ptr and ascending modulo NUM_REQ; the first set bit wins.
  - If no req_valid bit is set, there is no winner.
- req_ready[i] = can_accept & (winner==i). All other bits are 0, and all bits are 0 when can_accept=0.
  - req_ready may depend combinationally on req_valid and out_ready.
  - It must not depend on req_addr, req_tag or req_data.
- Transfer into the output register happens when req_valid[w] & req_ready[w] at the clock edge:
  - out_addr, out_tag and out_data load slot w; out_src<=w; out_valid<=1.
  - rr_ptr <= (w+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Output drain happens when out_valid & out_ready with no transfer in: out_valid<=0. Data registers hold their values (don't-care).
- Drain and transfer in the same cycle: the new message overwrites, out_valid stays 1, and there is no bubble. Sustained throughput is 1 message/cycle.
- No drain and no transfer: all registers hold and rr_ptr is unchanged.
- Latency: a request accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- out_* stay stable while out_valid=1 and out_ready=0 (valid/ready hold rule).
- Requester rule: a requester keeps req_valid and data stable until its req_ready. The arbiter does not check this.
- Fairness:
  - A continuously-valid requester is granted within NUM_REQ transfers.
  - rr_ptr advances only on an actual transfer; it never advances on stall or idle cycles.
- Single active requester: it gets every slot back-to-back. rr_ptr moves past it each time, but the search wraps back to it.
- Reset asserted mid-transfer: the held message is dropped and rr_ptr returns to 0. After release, arbitration resumes from index 0 with no spurious out_valid.
- No internal state machine beyond out_valid and rr_ptr. No configuration or priority inputs.

Test Plan:
- Reset, then req_valid=4'b1111 with out_ready=1 held for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3. out_valid=1 from the cycle after the first grant with no gaps. req_ready one-hot each cycle.
- out_valid=1 holding src 2 (addr=0x12, tag=0x05, data=0xDEAD), out_ready=0 for 5 cycles, req_valid=4'b1011 -> req_ready=0 and out_* unchanged for all 5 cycles. When out_ready=1, the next grant goes to index 3 (rr_ptr=3).
- Only req_valid[1] set, out_ready=1, 4 messages with data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles, out_src=1 each time.
- rr_ptr=3, req_valid=4'b1001 -> grant 3, then 0 (wrap-around), then 3.
- out_valid=1, out_ready=1, req_valid=0 -> out_valid=0 next cycle, rr_ptr unchanged. A later req_valid=4'b0100 gives out_src=2 one cycle after acceptance.
- rst_n pulsed low while out_valid=1 and rr_ptr=2 -> out_valid=0 and out_* zero immediately (asynchronous). After release, req_valid=4'b1111 is granted to index 0 first.
